reg_scoreboard: RTL and testbench

Read-after-write and write-after-write hazard scoreboard for the 32-entry integer register file.
- Tracks outstanding writes per architectural register. An instruction at the issue stage is held until its source registers are safe to read through the file's synchronous read ports.
- Sits between decode/issue and the register file.
- Issue side: issue handshake in, stall out.
- Writeback side: takes a write-completion pulse from the writeback stage, which drives the file's write_enable/rd.

---
 rtl/reg_scoreboard.sv | 106 ++++++++++
 tb/tb_reg_scoreboard.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/reg_scoreboard.sv
// rtl/reg_scoreboard.sv - RAW/WAW hazard scoreboard for the 32-entry integer register file.
// Per-register outstanding-write counters gate issue until sources are safe to read.
module reg_scoreboard #(
  parameter int PEND_MAX = 3,
  parameter int MAX_OUT  = 8,
  parameter int CNTW     = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  output logic            issue_ready,
  input  logic [4:0]      issue_r1,
  input  logic [4:0]      issue_r2,
  input  logic            issue_use_r1,
  input  logic            issue_use_r2,
  input  logic            issue_we,
  input  logic [4:0]      issue_rd,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic            flush,
  output logic [31:0]     busy_vec,
  output logic [CNTW-1:0] out_count,
  output logic            wb_underflow
);

  localparam int CW = $clog2(PEND_MAX + 1);

  logic [CW-1:0]   cnt    [32];
  logic [CW-1:0]   cnt_nx [32];
  logic [31:0]     busy_nx;
  logic [CNTW-1:0] count_nx;

  logic src1_hit;
  logic src2_hit;
  logic wr_req;
  logic wr_full;
  logic inc;
  logic wb_hit;
  logic wb_live;
  logic cancel;

  // A source stays blocked while its count is nonzero, even if writeback lands this
  // cycle: the file's synchronous read at this edge would still return the old data.
  assign src1_hit = issue_use_r1 && (issue_r1 != 5'd0) && (cnt[issue_r1] != '0);
  assign src2_hit = issue_use_r2 && (issue_r2 != 5'd0) && (cnt[issue_r2] != '0);
  assign wr_req   = issue_we && (issue_rd != 5'd0);
  assign wr_full  = (cnt[issue_rd] == CW'(PEND_MAX)) || (out_count == CNTW'(MAX_OUT));

  assign issue_ready = !flush && !src1_hit && !src2_hit && !(wr_req && wr_full);

  assign inc     = issue_valid && issue_ready && wr_req;
  assign wb_hit  = wb_valid && (wb_rd != 5'd0);
  assign wb_live = wb_hit && (cnt[wb_rd] != '0);
  assign cancel  = inc && wb_hit && (wb_rd == issue_rd);

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      cnt_nx[i] = cnt[i];
    end
    count_nx = out_count;
    if (!cancel) begin
      if (inc) begin
        cnt_nx[issue_rd] = cnt[issue_rd] + CW'(1);
      end
      if (wb_live) begin
        cnt_nx[wb_rd] = cnt[wb_rd] - CW'(1);
      end
      case ({inc, wb_live})
        2'b10:   count_nx = out_count + CNTW'(1);
        2'b01:   count_nx = out_count - CNTW'(1);
        default: count_nx = out_count;
      endcase
    end
    cnt_nx[0] = '0;
    for (int i = 0; i < 32; i++) begin
      busy_nx[i] = (cnt_nx[i] != '0);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) begin
        cnt[i] <= '0;
      end
      busy_vec     <= '0;
      out_count    <= '0;
      wb_underflow <= 1'b0;
    end else if (flush) begin
      for (int i = 0; i < 32; i++) begin
        cnt[i] <= '0;
      end
      busy_vec  <= '0;
      out_count <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        cnt[i] <= cnt_nx[i];
      end
      busy_vec  <= busy_nx;
      out_count <= count_nx;
      if (wb_hit && !wb_live) begin
        wb_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
// tb/tb_reg_scoreboard.sv - directed vector bench for reg_scoreboard.
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_r1;
  logic [4:0]  issue_r2;
  logic        issue_use_r1;
  logic        issue_use_r2;
  logic        issue_we;
  logic [4:0]  issue_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        flush;
  logic [31:0] busy_vec;
  logic [3:0]  out_count;
  logic        wb_underflow;

  int total;
  int bad;

  reg_scoreboard #(.PEND_MAX(3), .MAX_OUT(8), .CNTW(4)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_r1(issue_r1), .issue_r2(issue_r2),
    .issue_use_r1(issue_use_r1), .issue_use_r2(issue_use_r2),
    .issue_we(issue_we), .issue_rd(issue_rd),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .flush(flush),
    .busy_vec(busy_vec), .out_count(out_count), .wb_underflow(wb_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic        u1;
    logic [4:0]  r1;
    logic        u2;
    logic [4:0]  r2;
    logic        we;
    logic [4:0]  rd;
    logic        wbv;
    logic [4:0]  wbrd;
    logic        fl;
    logic        rdy;
    logic [31:0] busy;
    logic [3:0]  oc;
    logic        uf;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic v, logic u1, logic [4:0] r1, logic u2, logic [4:0] r2,
                              logic we, logic [4:0] rd, logic wbv, logic [4:0] wbrd, logic fl,
                              logic rdy, logic [31:0] busy, logic [3:0] oc, logic uf);
    vec_t t;
    t.v = v; t.u1 = u1; t.r1 = r1; t.u2 = u2; t.r2 = r2; t.we = we; t.rd = rd;
    t.wbv = wbv; t.wbrd = wbrd; t.fl = fl; t.rdy = rdy; t.busy = busy; t.oc = oc; t.uf = uf;
    return t;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t t);
    issue_valid = t.v; issue_use_r1 = t.u1; issue_r1 = t.r1;
    issue_use_r2 = t.u2; issue_r2 = t.r2; issue_we = t.we; issue_rd = t.rd;
    wb_valid = t.wbv; wb_rd = t.wbrd; flush = t.fl;
  endtask

  initial begin
    logic [31:0] acc;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    issue_we = 1'b1; issue_rd = 5'd5;
    #12;
    chk("reset_busy", busy_vec, 32'h0);
    chk("reset_count", {28'h0, out_count}, 32'h0);
    chk("reset_uf", {31'h0, wb_underflow}, 32'h0);
    chk("reset_ready", {31'h0, issue_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b0;

    vq.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 32'h20, 1, 0));
    vq.push_back(mk(1, 1, 5, 0, 0, 0, 0, 1, 5, 0, 0, 32'h0, 0, 0));
    vq.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 32'h80, 1, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 32'h80, 2, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 32'h80, 3, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 32'h80, 3, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 7, 1, 7, 0, 0, 32'h80, 2, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 32'h80, 3, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1, 32'h80, 2, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1, 32'h80, 1, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 1, 32'h0, 0, 0));
    acc = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      acc = acc | (32'h1 << k);
      vq.push_back(mk(1, 0, 0, 0, 0, 1, 5'(k), 0, 0, 0, 1, acc, 4'(k), 0));
    end
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 0, 32'h1FE, 8, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 1, 9, 1, 1, 0, 0, 32'h1FC, 7, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 9, 0, 0, 0, 1, 32'h3FC, 8, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 2, 0, 1, 32'h3F8, 7, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 1, 32'h3E8, 6, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 5, 0, 1, 32'h3C8, 5, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 6, 0, 1, 32'h388, 4, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 3, 1, 0, 32'h0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 12, 1, 0, 32'h0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 10, 0, 1, 32'h0, 0, 1));
    vq.push_back(mk(1, 1, 0, 0, 0, 1, 0, 1, 0, 0, 1, 32'h0, 0, 1));
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 0, 1, 32'h10, 1, 1));
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 6, 1, 4, 0, 1, 32'h40, 1, 1));
    vq.push_back(mk(1, 0, 0, 0, 0, 1, 6, 1, 6, 0, 1, 32'h40, 1, 1));
    vq.push_back(mk(1, 0, 0, 1, 6, 0, 0, 0, 0, 0, 0, 32'h40, 1, 1));
    vq.push_back(mk(1, 1, 0, 1, 0, 0, 0, 0, 0, 0, 1, 32'h40, 1, 1));

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      drive(vq[i]);
      #1;
      chk($sformatf("v%0d_ready", i), {31'h0, issue_ready}, {31'h0, vq[i].rdy});
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_busy", i), busy_vec, vq[i].busy);
      chk($sformatf("v%0d_count", i), {28'h0, out_count}, {28'h0, vq[i].oc});
      chk($sformatf("v%0d_uf", i), {31'h0, wb_underflow}, {31'h0, vq[i].uf});
    end

    // Asynchronous reset in the middle of a cycle with x6 busy and underflow set.
    @(negedge clk);
    drive(mk(0, 1, 6, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    #1;
    chk("pre_reset_ready", {31'h0, issue_ready}, 32'h0);
    rst = 1'b1;
    #1;
    chk("mid_reset_busy", busy_vec, 32'h0);
    chk("mid_reset_count", {28'h0, out_count}, 32'h0);
    chk("mid_reset_uf", {31'h0, wb_underflow}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    issue_valid = 1'b1;
    #1;
    chk("post_reset_ready", {31'h0, issue_ready}, 32'h1);
    @(posedge clk);
    #1;
    chk("post_reset_busy", busy_vec, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
